alarm_trigger_ctrl: RTL and testbench

//  Initiator side of the buzzer trigger interface: decides when the beeper fires.

---
 rtl/alarm_trigger_ctrl_pkg.sv | 18 +
 rtl/alarm_trigger_ctrl.sv | 148 ++++++++++++++
 tb/tb_alarm_trigger_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_ctrl_pkg.sv
// Shared definitions for the alarm trigger controller:
// state encoding, BCD field width and parameter defaults.
package alarm_trigger_ctrl_pkg;

    localparam int BCD_W = 8;

    localparam int DEF_RING_PERIOD = 2;
    localparam int DEF_MAX_RINGS   = 30;
    localparam int DEF_SNOOZE_SEC  = 300;
    localparam int DEF_MAX_SNOOZE  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/alarm_trigger_ctrl.sv
// Buzzer trigger initiator: alarm match, periodic ringing,
// snooze/stop/auto-off and the hourly chime pulse.
module alarm_trigger_ctrl
    import alarm_trigger_ctrl_pkg::*;
#(
    parameter int RING_PERIOD = DEF_RING_PERIOD,
    parameter int MAX_RINGS   = DEF_MAX_RINGS,
    parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC,
    parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic             Reset_N,
    input  logic             Clk_50MHz,
    input  logic             Sec_tick,
    input  logic [BCD_W-1:0] Cur_hour,
    input  logic [BCD_W-1:0] Cur_min,
    input  logic [BCD_W-1:0] Cur_sec,
    input  logic [BCD_W-1:0] Alarm_hour,
    input  logic [BCD_W-1:0] Alarm_min,
    input  logic             Alarm_en,
    input  logic             Chime_en,
    input  logic             Key_stop,
    input  logic             Key_snooze,
    output logic             Buzzer_trigger,
    output logic             Alarm_active,
    output logic             Snooze_active
);

    localparam int RW = $clog2(MAX_RINGS + 1);
    localparam int PW = $clog2(RING_PERIOD + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam int NW = $clog2(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RINGS_MAX = RW'(MAX_RINGS);
    localparam logic [PW-1:0] PER_MAX   = PW'(RING_PERIOD);
    localparam logic [SW-1:0] SNZ_LEN   = SW'(SNOOZE_SEC);
    localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);

    alarm_state_e  state;
    logic [RW-1:0] ring_cnt;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] snooze_cnt;
    logic [NW-1:0] snooze_num;

    logic          match;
    logic          chime;
    logic [PW-1:0] period_nxt;

    assign match = Sec_tick & Alarm_en
                 & (Cur_sec == 8'h00)
                 & (Cur_hour == Alarm_hour)
                 & (Cur_min == Alarm_min);

    assign chime = Sec_tick & Chime_en
                 & (Cur_min == 8'h00)
                 & (Cur_sec == 8'h00);

    assign period_nxt = (period_cnt >= PER_MAX) ? PER_MAX
                                                : period_cnt + PW'(1);

    always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
        if (!Reset_N) begin
            state          <= ST_IDLE;
            ring_cnt       <= '0;
            period_cnt     <= '0;
            snooze_cnt     <= '0;
            snooze_num     <= '0;
            Buzzer_trigger <= 1'b0;
            Alarm_active   <= 1'b0;
            Snooze_active  <= 1'b0;
        end else begin
            Buzzer_trigger <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Alarm takes precedence; a coincident chime adds no pulse.
                    if (match) begin
                        state          <= ST_RINGING;
                        Buzzer_trigger <= 1'b1;
                        ring_cnt       <= RW'(1);
                        period_cnt     <= '0;
                        snooze_num     <= '0;
                        Alarm_active   <= 1'b1;
                        Snooze_active  <= 1'b0;
                    end else if (chime) begin
                        Buzzer_trigger <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (!Alarm_en || Key_stop) begin
                        state         <= ST_IDLE;
                        Alarm_active  <= 1'b0;
                        Snooze_active <= 1'b0;
                    end else if (Key_snooze) begin
                        if (snooze_num < SNZ_MAX) begin
                            state         <= ST_SNOOZE;
                            snooze_cnt    <= SNZ_LEN;
                            snooze_num    <= snooze_num + NW'(1);
                            Snooze_active <= 1'b1;
                        end else begin
                            state         <= ST_IDLE;
                            Alarm_active  <= 1'b0;
                            Snooze_active <= 1'b0;
                        end
                    end else if (Sec_tick) begin
                        if (period_nxt == PER_MAX) begin
                            if (ring_cnt >= RINGS_MAX) begin
                                state         <= ST_IDLE;
                                period_cnt    <= period_nxt;
                                Alarm_active  <= 1'b0;
                                Snooze_active <= 1'b0;
                            end else begin
                                Buzzer_trigger <= 1'b1;
                                ring_cnt       <= ring_cnt + RW'(1);
                                period_cnt     <= '0;
                            end
                        end else begin
                            period_cnt <= period_nxt;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (!Alarm_en || Key_stop) begin
                        state         <= ST_IDLE;
                        Alarm_active  <= 1'b0;
                        Snooze_active <= 1'b0;
                    end else if (Sec_tick) begin
                        // Ringing resumes on the tick that empties the counter.
                        if (snooze_cnt <= SW'(1)) begin
                            state          <= ST_RINGING;
                            snooze_cnt     <= '0;
                            Buzzer_trigger <= 1'b1;
                            ring_cnt       <= RW'(1);
                            period_cnt     <= '0;
                            Snooze_active  <= 1'b0;
                        end else begin
                            snooze_cnt <= snooze_cnt - SW'(1);
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    Alarm_active  <= 1'b0;
                    Snooze_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Directed bench for alarm_trigger_ctrl with small ring/snooze
// parameters and a Sec_tick issued every couple of clocks.
module tb_alarm_trigger_ctrl;

    logic       Reset_N;
    logic       Clk_50MHz;
    logic       Sec_tick;
    logic [7:0] Cur_hour;
    logic [7:0] Cur_min;
    logic [7:0] Cur_sec;
    logic [7:0] Alarm_hour;
    logic [7:0] Alarm_min;
    logic       Alarm_en;
    logic       Chime_en;
    logic       Key_stop;
    logic       Key_snooze;
    logic       Buzzer_trigger;
    logic       Alarm_active;
    logic       Snooze_active;

    int checks = 0;
    int errors = 0;

    alarm_trigger_ctrl #(
        .RING_PERIOD (2),
        .MAX_RINGS   (3),
        .SNOOZE_SEC  (5),
        .MAX_SNOOZE  (1)
    ) dut (
        .Reset_N        (Reset_N),
        .Clk_50MHz      (Clk_50MHz),
        .Sec_tick       (Sec_tick),
        .Cur_hour       (Cur_hour),
        .Cur_min        (Cur_min),
        .Cur_sec        (Cur_sec),
        .Alarm_hour     (Alarm_hour),
        .Alarm_min      (Alarm_min),
        .Alarm_en       (Alarm_en),
        .Chime_en       (Chime_en),
        .Key_stop       (Key_stop),
        .Key_snooze     (Key_snooze),
        .Buzzer_trigger (Buzzer_trigger),
        .Alarm_active   (Alarm_active),
        .Snooze_active  (Snooze_active)
    );

    initial Clk_50MHz = 1'b0;
    always #10 Clk_50MHz = ~Clk_50MHz;

    // One Sec_tick cycle; returns on the falling edge after the
    // active edge so the registered response can be sampled.
    task automatic tick(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
        @(negedge Clk_50MHz);
        Cur_hour = h;
        Cur_min  = m;
        Cur_sec  = s;
        Sec_tick = 1'b1;
        @(negedge Clk_50MHz);
        Sec_tick = 1'b0;
    endtask

    task automatic key(input logic stop, input logic snooze);
        @(negedge Clk_50MHz);
        Key_stop   = stop;
        Key_snooze = snooze;
        @(negedge Clk_50MHz);
        Key_stop   = 1'b0;
        Key_snooze = 1'b0;
    endtask

    task automatic test_reset;
        Reset_N = 1'b0;
        repeat (2) @(negedge Clk_50MHz);
        checks++;
        if ({Buzzer_trigger, Alarm_active, Snooze_active} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000",
                     {Buzzer_trigger, Alarm_active, Snooze_active});
        end
        Reset_N = 1'b1;
        @(negedge Clk_50MHz);
    endtask

    task automatic test_ring_auto_off;
        logic exp;
        tick(8'h07, 8'h29, 8'h59);
        checks++;
        if (Buzzer_trigger !== 1'b0) begin
            errors++;
            $display("FAIL t1_premature got %b exp 0", Buzzer_trigger);
        end
        tick(8'h07, 8'h30, 8'h00);
        checks++;
        if ({Buzzer_trigger, Alarm_active} !== 2'b11) begin
            errors++;
            $display("FAIL t1_first_pulse got %b exp 11",
                     {Buzzer_trigger, Alarm_active});
        end
        @(negedge Clk_50MHz);
        checks++;
        if (Buzzer_trigger !== 1'b0) begin
            errors++;
            $display("FAIL t1_pulse_width got %b exp 0", Buzzer_trigger);
        end
        for (int i = 1; i <= 6; i++) begin
            tick(8'h07, 8'h30, 8'(i));
            exp = (i == 2 || i == 4);
            checks++;
            if (Buzzer_trigger !== exp) begin
                errors++;
                $display("FAIL t1_ring_s%0d got %b exp %b",
                         i, Buzzer_trigger, exp);
            end
        end
        checks++;
        if (Alarm_active !== 1'b0) begin
            errors++;
            $display("FAIL t1_auto_off got %b exp 0", Alarm_active);
        end
    endtask

    task automatic test_snooze;
        logic exp;
        tick(8'h07, 8'h30, 8'h00);
        tick(8'h07, 8'h30, 8'h01);
        key(1'b0, 1'b1);
        checks++;
        if ({Alarm_active, Snooze_active} !== 2'b11) begin
            errors++;
            $display("FAIL t2_enter_snooze got %b exp 11",
                     {Alarm_active, Snooze_active});
        end
        for (int i = 1; i <= 5; i++) begin
            tick(8'h07, 8'h30, 8'(1 + i));
            exp = (i == 5);
            checks++;
            if (Buzzer_trigger !== exp) begin
                errors++;
                $display("FAIL t2_snooze_t%0d got %b exp %b",
                         i, Buzzer_trigger, exp);
            end
            if (i == 2) key(1'b0, 1'b1);
        end
        checks++;
        if ({Alarm_active, Snooze_active} !== 2'b10) begin
            errors++;
            $display("FAIL t2_resume got %b exp 10",
                     {Alarm_active, Snooze_active});
        end
        key(1'b0, 1'b1);
        checks++;
        if ({Alarm_active, Snooze_active} !== 2'b00) begin
            errors++;
            $display("FAIL t2_snooze_limit got %b exp 00",
                     {Alarm_active, Snooze_active});
        end
    endtask

    task automatic test_stop_and_snooze;
        int pulses = 0;
        tick(8'h07, 8'h30, 8'h00);
        key(1'b1, 1'b1);
        checks++;
        if ({Alarm_active, Snooze_active} !== 2'b00) begin
            errors++;
            $display("FAIL t3_stop_wins got %b exp 00",
                     {Alarm_active, Snooze_active});
        end
        for (int i = 1; i <= 3; i++) begin
            tick(8'h07, 8'h30, 8'(i));
            pulses += int'(Buzzer_trigger);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL t3_no_pulse got %0d exp 0", pulses);
        end
    endtask

    task automatic test_chime;
        Alarm_en = 1'b0;
        Chime_en = 1'b1;
        tick(8'h08, 8'h00, 8'h00);
        checks++;
        if ({Buzzer_trigger, Alarm_active} !== 2'b10) begin
            errors++;
            $display("FAIL t4_chime got %b exp 10",
                     {Buzzer_trigger, Alarm_active});
        end
        tick(8'h08, 8'h00, 8'h01);
        checks++;
        if (Buzzer_trigger !== 1'b0) begin
            errors++;
            $display("FAIL t4_chime_once got %b exp 0", Buzzer_trigger);
        end
        Alarm_hour = 8'h08;
        Alarm_min  = 8'h00;
        Alarm_en   = 1'b1;
        tick(8'h08, 8'h00, 8'h00);
        checks++;
        if ({Buzzer_trigger, Alarm_active} !== 2'b11) begin
            errors++;
            $display("FAIL t4_alarm_chime got %b exp 11",
                     {Buzzer_trigger, Alarm_active});
        end
        @(negedge Clk_50MHz);
        checks++;
        if (Buzzer_trigger !== 1'b0) begin
            errors++;
            $display("FAIL t4_single_pulse got %b exp 0", Buzzer_trigger);
        end
        key(1'b0, 1'b1);
        tick(8'h09, 8'h00, 8'h00);
        checks++;
        if ({Buzzer_trigger, Snooze_active} !== 2'b01) begin
            errors++;
            $display("FAIL t4_chime_in_snooze got %b exp 01",
                     {Buzzer_trigger, Snooze_active});
        end
        key(1'b1, 1'b0);
        checks++;
        if (Alarm_active !== 1'b0) begin
            errors++;
            $display("FAIL t4_stop_snooze got %b exp 0", Alarm_active);
        end
        Chime_en   = 1'b0;
        Alarm_hour = 8'h07;
        Alarm_min  = 8'h30;
    endtask

    task automatic test_reset_mid_snooze;
        int pulses = 0;
        tick(8'h07, 8'h30, 8'h00);
        key(1'b0, 1'b1);
        checks++;
        if (Snooze_active !== 1'b1) begin
            errors++;
            $display("FAIL t5_in_snooze got %b exp 1", Snooze_active);
        end
        #3 Reset_N = 1'b0;
        #1;
        checks++;
        if ({Buzzer_trigger, Alarm_active, Snooze_active} !== 3'b000) begin
            errors++;
            $display("FAIL t5_async_reset got %b exp 000",
                     {Buzzer_trigger, Alarm_active, Snooze_active});
        end
        @(negedge Clk_50MHz);
        Reset_N = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(8'h07, 8'h30, 8'(i));
            pulses += int'(Buzzer_trigger);
        end
        checks++;
        if (pulses != 0 || Alarm_active !== 1'b0) begin
            errors++;
            $display("FAIL t5_after_release got %0d/%b exp 0/0",
                     pulses, Alarm_active);
        end
    endtask

    task automatic test_alarm_en_drop;
        int pulses = 0;
        tick(8'h07, 8'h30, 8'h00);
        tick(8'h07, 8'h30, 8'h01);
        @(negedge Clk_50MHz);
        Cur_sec  = 8'h02;
        Sec_tick = 1'b1;
        Alarm_en = 1'b0;
        @(negedge Clk_50MHz);
        Sec_tick = 1'b0;
        checks++;
        if ({Buzzer_trigger, Alarm_active} !== 2'b00) begin
            errors++;
            $display("FAIL t6_en_drop got %b exp 00",
                     {Buzzer_trigger, Alarm_active});
        end
        Alarm_en = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            tick(8'h07, 8'h30, 8'(i));
            pulses += int'(Buzzer_trigger);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL t6_stays_idle got %0d exp 0", pulses);
        end
    endtask

    initial begin
        Reset_N    = 1'b0;
        Sec_tick   = 1'b0;
        Cur_hour   = 8'h07;
        Cur_min    = 8'h29;
        Cur_sec    = 8'h59;
        Alarm_hour = 8'h07;
        Alarm_min  = 8'h30;
        Alarm_en   = 1'b1;
        Chime_en   = 1'b0;
        Key_stop   = 1'b0;
        Key_snooze = 1'b0;

        test_reset;
        test_ring_auto_off;
        test_snooze;
        test_stop_and_snooze;
        test_chime;
        test_reset_mid_snooze;
        test_alarm_en_drop;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
